// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control FSM: states, opcode/funct fields, ALU and mux selects.
// Pure definitions; no latency and no backpressure involved.
package control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_IMM_EXEC  = 4'd10,
    ST_IMM_WB    = 4'd11,
    ST_TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic opcode_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_SLTI: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  // Final phase of every instruction class; leaving it retires the instruction.
  function automatic logic is_retire_state(input state_t s);
    case (s)
      ST_MEM_WB, ST_MEM_WRITE, ST_R_WB, ST_BRANCH, ST_JUMP, ST_IMM_WB: return 1'b1;
      default:                                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALUOp select from (state, opcode, funct) plus an R-type funct legality flag.
// Zero latency; no flow control.
module alu_op_decoder
  import control_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       funct_legal
);

  logic [3:0] rtype_op;

  always_comb begin
    funct_legal = 1'b1;
    rtype_op    = ALU_AND;
    case (funct)
      FN_ADD:  rtype_op = ALU_ADD;
      FN_SUB:  rtype_op = ALU_SUB;
      FN_AND:  rtype_op = ALU_AND;
      FN_OR:   rtype_op = ALU_OR;
      FN_NOR:  rtype_op = ALU_NOR;
      FN_SLT:  rtype_op = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_op = ALU_AND;
    case (state_t'(state))
      ST_FETCH, ST_DECODE, ST_MEM_ADDR: alu_op = ALU_ADD;
      ST_EXECUTE:                       alu_op = rtype_op;
      ST_BRANCH:                        alu_op = ALU_SUB;
      ST_IMM_EXEC:                      alu_op = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      default:                          alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: 3-5 cycles per instruction, Moore outputs, no stalls accepted.
// ILLEGAL_TRAP_EN: when defined, illegal instructions park the FSM in TRAP until reset.
module multicycle_control
  import control_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic [1:0]           PCSource,
  output logic [3:0]           ALUOp,
  output logic [1:0]           ALUSrcB,
  output logic                 ALUSrcA,
  output logic                 RegWrite,
  output logic                 RegDst,
  output logic [3:0]           state,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] instr_retired
);

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_DEST = ST_TRAP;
`else
  localparam state_t ILLEGAL_DEST = ST_FETCH;
`endif

  state_t     state_q;
  logic [3:0] dec_alu_op;
  logic       funct_legal;
  logic       instr_legal;

  assign state = state_q;

  alu_op_decoder u_alu_op_decoder (
    .state       (state_q),
    .opcode      (opcode),
    .funct       (funct),
    .alu_op      (dec_alu_op),
    .funct_legal (funct_legal)
  );

  // funct is screened here so EXECUTE can trust it.
  assign instr_legal = opcode_supported(opcode) && ((opcode != OP_RTYPE) || funct_legal);

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      instr_retired <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_FETCH: state_q <= ST_DECODE;
        ST_DECODE: begin
          if (!instr_legal) begin
            state_q <= ILLEGAL_DEST;
          end else begin
            case (opcode)
              OP_LW, OP_SW:     state_q <= ST_MEM_ADDR;
              OP_RTYPE:         state_q <= ST_EXECUTE;
              OP_BEQ:           state_q <= ST_BRANCH;
              OP_J:             state_q <= ST_JUMP;
              OP_ADDI, OP_SLTI: state_q <= ST_IMM_EXEC;
              default:          state_q <= ILLEGAL_DEST;
            endcase
          end
        end
        ST_MEM_ADDR:  state_q <= (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
        ST_MEM_READ:  state_q <= ST_MEM_WB;
        ST_EXECUTE:   state_q <= ST_R_WB;
        ST_IMM_EXEC:  state_q <= ST_IMM_WB;
`ifdef ILLEGAL_TRAP_EN
        ST_TRAP:      state_q <= ST_TRAP;
`endif
        default:      state_q <= ST_FETCH;
      endcase

      if (is_retire_state(state_q)) begin
        instr_retired <= instr_retired + CNT_WIDTH'(1);
      end

`ifdef ILLEGAL_TRAP_EN
      illegal_q <= ((state_q == ST_DECODE) && !instr_legal) || (state_q == ST_TRAP);
`endif
    end
  end

  // Outputs are forced low while reset is asserted so nothing can write during a reset.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUOp       = reset ? ALU_AND : dec_alu_op;
    ALUSrcB     = SRCB_B;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcB = SRCB_FOUR;
        end
        ST_DECODE:   ALUSrcB = SRCB_IMM_SH2;
        ST_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        ST_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        ST_MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        ST_MEM_WRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        ST_EXECUTE:  ALUSrcA = 1'b1;
        ST_R_WB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        ST_BRANCH: begin
          ALUSrcA     = 1'b1;
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
        end
        ST_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
        end
        ST_IMM_EXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        ST_IMM_WB:   RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: random instruction mix against an instruction-class path model,
// plus directed reset, mid-instruction reset, counter wrap and illegal-opcode cases.
module tb_multicycle_control;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic [1:0]    PCSource;
  logic [3:0]    ALUOp;
  logic [1:0]    ALUSrcB;
  logic          ALUSrcA, RegWrite, RegDst;
  logic [3:0]    state;
  logic          illegal;
  logic [CW-1:0] instr_retired;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .PCSource(PCSource),
    .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .state(state), .illegal(illegal), .instr_retired(instr_retired)
  );

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r;
    logic [1:0] pcsrc;
    logic [3:0] aluop;
    logic [1:0] srcb;
    logic       srca, rw, rdst;
  } ctrl_t;

  ctrl_t obs;
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst};

  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] model_cnt;
  int            path[$];
  logic [5:0]    legal_fn[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
  logic [5:0]    op_r, fn_r;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic bit op_supported(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b001010};
  endfunction

  function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
    if (!op_supported(op)) return 1'b0;
    if (op == 6'b000000) return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
    return 1'b1;
  endfunction

  function automatic logic [3:0] rtype_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100111: return 4'b1100;
      6'b101010: return 4'b0111;
      default:   return 4'bxxxx;
    endcase
  endfunction

  // Control lines expected in each phase, straight from the state table.
  function automatic ctrl_t exp_ctrl(input int st, input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c = '0;
    case (st)
      0:  begin c.pcw = 1; c.mrd = 1; c.irw = 1; c.srcb = 2'b01; c.aluop = 4'b0010; end
      1:  begin c.srcb = 2'b11; c.aluop = 4'b0010; end
      2:  begin c.srca = 1; c.srcb = 2'b10; c.aluop = 4'b0010; end
      3:  begin c.mrd = 1; c.iord = 1; end
      4:  begin c.rw = 1; c.m2r = 1; end
      5:  begin c.mwr = 1; c.iord = 1; end
      6:  begin c.srca = 1; c.aluop = rtype_alu(fn); end
      7:  begin c.rw = 1; c.rdst = 1; end
      8:  begin c.srca = 1; c.aluop = 4'b0110; c.pcwc = 1; c.pcsrc = 2'b01; end
      9:  begin c.pcw = 1; c.pcsrc = 2'b10; end
      10: begin c.srca = 1; c.srcb = 2'b10; c.aluop = (op == 6'b001010) ? 4'b0111 : 4'b0010; end
      11: c.rw = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Phase sequence of one instruction, FETCH up to the phase before the next FETCH.
  task automatic build_path(input logic [5:0] op, input logic [5:0] fn);
    path = '{0, 1};
    if (is_legal(op, fn)) begin
      case (op)
        6'b100011: path = '{0, 1, 2, 3, 4};
        6'b101011: path = '{0, 1, 2, 5};
        6'b000000: path = '{0, 1, 6, 7};
        6'b000100: path = '{0, 1, 8};
        6'b000010: path = '{0, 1, 9};
        default:   path = '{0, 1, 10, 11};
      endcase
    end
  endtask

  // Entered and left at negedge+1 within a FETCH cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
    build_path(op, fn);
    opcode = op;
    funct  = fn;
    #1;
    for (int i = 0; i < path.size(); i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      check("state", 32'(state), 32'(path[i]));
      check("ctrl", 32'(obs), 32'(exp_ctrl(path[i], op, fn)));
      check("count", 32'(instr_retired), 32'(model_cnt));
      check("illegal", 32'(illegal), 32'(0));
    end
    @(negedge clk);
    #1;
    if (is_legal(op, fn)) model_cnt = model_cnt + 1'b1;
  endtask

  task automatic pick(input bit allow_illegal, output logic [5:0] op, output logic [5:0] fn);
    int k;
    k  = allow_illegal ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 6));
    fn = 6'($urandom);
    case (k)
      0: op = 6'b100011;
      1: op = 6'b101011;
      2: begin op = 6'b000000; fn = legal_fn[$urandom_range(0, 5)]; end
      3: op = 6'b001000;
      4: op = 6'b001010;
      5: op = 6'b000100;
      6: op = 6'b000010;
      default: begin
        if ($urandom_range(0, 1) == 1) begin
          do op = 6'($urandom); while (op_supported(op));
        end else begin
          op = 6'b000000;
          do fn = 6'($urandom); while (is_legal(op, fn));
        end
      end
    endcase
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 6'b0;
    funct  = 6'b0;
    model_cnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 32'(obs), 32'(0));
    check("rst_state", 32'(state), 32'(0));
    check("rst_count", 32'(instr_retired), 32'(0));
    check("rst_illegal", 32'(illegal), 32'(0));
    reset = 1'b0;
    #1;
    check("first_fetch", 32'(obs), 32'(exp_ctrl(0, 6'b0, 6'b0)));

    run_instr(6'b100011, 6'b0);          // lw
    check("lw_count", 32'(instr_retired), 32'(1));
    run_instr(6'b000000, 6'b100010);     // sub
    run_instr(6'b000000, 6'b101010);     // slt
    run_instr(6'b000100, 6'b0);          // beq
    run_instr(6'b000010, 6'b0);          // j
    check("dir_count", 32'(instr_retired), 32'(5));

    for (int n = 0; n < 40; n++) begin
`ifdef ILLEGAL_TRAP_EN
      pick(1'b0, op_r, fn_r);
`else
      pick(1'b1, op_r, fn_r);
`endif
      run_instr(op_r, fn_r);
    end

    // Reset lands in the MEM_WRITE phase of a store.
    opcode = 6'b101011;
    funct  = 6'($urandom);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("sw_pre_state", 32'(state), 32'(i == 2 ? 2 : i));
      @(negedge clk);
      #1;
    end
    check("sw_state", 32'(state), 32'(5));
    check("sw_memwrite", 32'(MemWrite), 32'(1));
    reset = 1'b1;
    #1;
    check("sw_rst_ctrl", 32'(obs), 32'(0));
    @(negedge clk);
    #1;
    check("sw_rst_state", 32'(state), 32'(0));
    check("sw_rst_memwrite", 32'(MemWrite), 32'(0));
    check("sw_rst_count", 32'(instr_retired), 32'(0));
    model_cnt = '0;
    reset = 1'b0;
    #1;
    check("sw_rst_fetch", 32'(obs), 32'(exp_ctrl(0, 6'b0, 6'b0)));

    for (int n = 0; n < 15; n++) begin
      pick(1'b0, op_r, fn_r);
      run_instr(op_r, fn_r);
    end
    check("count_15", 32'(instr_retired), 32'(15));
    pick(1'b0, op_r, fn_r);
    run_instr(op_r, fn_r);
    check("count_wrap", 32'(instr_retired), 32'(0));

`ifdef ILLEGAL_TRAP_EN
    opcode = 6'b111111;
    #1;
    check("trap_fetch", 32'(state), 32'(0));
    @(negedge clk);
    #1;
    check("trap_decode", 32'(state), 32'(1));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check("trap_state", 32'(state), 32'(12));
      check("trap_flag", 32'(illegal), 32'(1));
      check("trap_ctrl", 32'(obs), 32'(0));
      check("trap_count", 32'(instr_retired), 32'(model_cnt));
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("trap_rst_state", 32'(state), 32'(0));
    check("trap_rst_flag", 32'(illegal), 32'(0));
    reset = 1'b0;
`else
    run_instr(6'b111111, 6'b0);
    check("illegal_state", 32'(state), 32'(0));
    check("illegal_count", 32'(instr_retired), 32'(model_cnt));
    run_instr(6'b000000, 6'b000001);
    check("bad_funct_count", 32'(instr_retired), 32'(model_cnt));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
